mmio_bigreg_bridge: RTL and testbench

Parametrised bridge between MMIO word accesses and one wide "big register" of NUM_WORDS words, plus its valid index. It generalises the PS_BIGREG/RTL_BIGREG handling: per-word fresh tracking, an atomic commit through the valid index, and tear-free snapshots. DIR selects the direction: PS-to-RTL (seeds, chan_mux, sdc) or RTL-to-PS (buff_timestamp). One instance sits between the MMIO decoder and each big-register consumer or producer.

---
 rtl/mmio_bigreg_bridge_pkg.sv | 13 +
 rtl/mmio_bigreg_bridge_timeout_ctr.sv | 36 +++
 rtl/mmio_bigreg_bridge.sv | 181 ++++++++++++++++++
 tb/tb_mmio_bigreg_bridge.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mmio_bigreg_bridge_pkg.sv
// rtl/mmio_bigreg_bridge_pkg.sv - shared response codes, direction and FSM state types for the big-register bridge
package mmio_bigreg_bridge_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {BIGREG_PS2RTL = 1'b0, BIGREG_RTL2PS = 1'b1} bigreg_dir_t;

  typedef enum logic {ST_IDLE, ST_PENDING} ps2rtl_state_t;
  typedef enum logic {ST_EMPTY, ST_FULL} rtl2ps_state_t;

endpackage

// File: rtl/mmio_bigreg_bridge_timeout_ctr.sv
// rtl/mmio_bigreg_bridge_timeout_ctr.sv - stale partial-write counter: load, decrement, expire
module bigreg_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic dec_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // A load in the expiry cycle suppresses the expiry.
  assign expire_o = dec_i && !load_i && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(TIMEOUT_CYCLES - 1);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mmio_bigreg_bridge.sv
// rtl/mmio_bigreg_bridge.sv - MMIO word accesses to one wide big register with atomic commit / tear-free snapshot
// Optional stale partial-write timeout (DIR=0) enabled by BIGREG_TIMEOUT_EN.
module mmio_bigreg_bridge
  import mmio_bigreg_bridge_pkg::*;
#(
  parameter int NUM_WORDS      = 8,
  parameter int WORD_WIDTH     = 16,
  parameter int DIR            = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            ps_wr_en_i,
  input  logic [$clog2(NUM_WORDS+1):0]    ps_wr_idx_i,
  input  logic [WORD_WIDTH-1:0]           ps_wr_data_i,
  output logic [1:0]                      ps_wr_resp_o,
  output logic                            ps_wr_resp_valid_o,
  input  logic                            ps_rd_en_i,
  input  logic [$clog2(NUM_WORDS+1):0]    ps_rd_idx_i,
  output logic [WORD_WIDTH-1:0]           ps_rd_data_o,
  output logic                            ps_rd_valid_o,
  output logic [NUM_WORDS*WORD_WIDTH-1:0] rtl_out_data_o,
  output logic                            rtl_out_valid_o,
  input  logic                            rtl_out_ready_i,
  input  logic [NUM_WORDS*WORD_WIDTH-1:0] rtl_in_data_i,
  input  logic                            rtl_in_valid_i,
  output logic                            rtl_in_ready_o,
  output logic                            timeout_err_o
);

  localparam int IW = $clog2(NUM_WORDS + 1) + 1;
  localparam logic [IW-1:0] VIDX = IW'(NUM_WORDS);
  localparam bigreg_dir_t MODE = (DIR == 0) ? BIGREG_PS2RTL : BIGREG_RTL2PS;

  // words_q is the staging area (DIR=0) or the frozen snapshot (DIR=1).
  logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] words_q, words_d, out_q, out_d;
  logic [NUM_WORDS-1:0] fresh_q, fresh_d;
  ps2rtl_state_t        pst_q, pst_d;
  rtl2ps_state_t        rst_st_q, rst_st_d;
  logic                 out_valid_q, out_valid_d, in_ready_q, in_ready_d;
  logic [1:0]           wr_resp_q, wr_resp_d;
  logic                 wr_resp_valid_q, wr_resp_valid_d;
  logic [WORD_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d, timeout_err_q, timeout_err_d;
  logic                 word_wr, all_fresh, partial, expire;

  assign word_wr   = ps_wr_en_i && (ps_wr_idx_i < VIDX);
  assign all_fresh = &fresh_q;
  assign partial   = (|fresh_q) && !all_fresh;

`ifdef BIGREG_TIMEOUT_EN
  bigreg_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  ((MODE == BIGREG_PS2RTL) && word_wr),
    .dec_i   ((MODE == BIGREG_PS2RTL) && partial),
    .expire_o(expire)
  );
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    words_d         = words_q;
    out_d           = out_q;
    fresh_d         = fresh_q;
    pst_d           = pst_q;
    rst_st_d        = rst_st_q;
    out_valid_d     = out_valid_q;
    in_ready_d      = 1'b0;
    wr_resp_d       = RESP_OKAY;
    wr_resp_valid_d = ps_wr_en_i;
    rd_data_d       = '0;
    rd_valid_d      = ps_rd_en_i;
    timeout_err_d   = 1'b0;
    if (MODE == BIGREG_PS2RTL) begin
      if (expire) begin
        fresh_d       = '0;
        timeout_err_d = 1'b1;
      end
      if ((pst_q == ST_PENDING) && out_valid_q && rtl_out_ready_i) begin
        pst_d       = ST_IDLE;
        out_valid_d = 1'b0;
      end
      if (ps_wr_en_i) begin
        if (ps_wr_idx_i > VIDX) begin
          wr_resp_d = RESP_DECERR;
        end else if (ps_wr_idx_i == VIDX) begin
          // A same-cycle handshake frees the slot, so the commit may take it.
          if (all_fresh && (pst_d == ST_IDLE)) begin
            out_d       = words_q;
            fresh_d     = '0;
            out_valid_d = 1'b1;
            pst_d       = ST_PENDING;
          end else begin
            wr_resp_d = RESP_SLVERR;
          end
        end else begin
          for (int i = 0; i < NUM_WORDS; i++) begin
            if (ps_wr_idx_i == IW'(i)) begin
              words_d[i] = ps_wr_data_i;
              fresh_d[i] = 1'b1;
            end
          end
        end
      end
      if (ps_rd_en_i && (ps_rd_idx_i == VIDX)) begin
        rd_data_d = WORD_WIDTH'({pst_q == ST_PENDING, all_fresh});
      end
    end else begin
      if (rtl_in_valid_i && in_ready_q) begin
        words_d  = rtl_in_data_i;
        rst_st_d = ST_FULL;
      end
      if (ps_wr_en_i) begin
        if (ps_wr_idx_i > VIDX) begin
          wr_resp_d = RESP_DECERR;
        end else if (ps_wr_idx_i == VIDX) begin
          if (rst_st_q == ST_FULL) begin
            rst_st_d = ST_EMPTY;
          end
        end else begin
          wr_resp_d = RESP_SLVERR;
        end
      end
      if (ps_rd_en_i && (ps_rd_idx_i == VIDX)) begin
        rd_data_d = WORD_WIDTH'(rst_st_q == ST_FULL);
      end
      in_ready_d = (rst_st_d == ST_EMPTY);
    end
    if (ps_rd_en_i) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (ps_rd_idx_i == IW'(i)) begin
          rd_data_d = words_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      words_q         <= '0;
      out_q           <= '0;
      fresh_q         <= '0;
      pst_q           <= ST_IDLE;
      rst_st_q        <= ST_EMPTY;
      out_valid_q     <= 1'b0;
      in_ready_q      <= 1'b0;
      wr_resp_q       <= RESP_OKAY;
      wr_resp_valid_q <= 1'b0;
      rd_data_q       <= '0;
      rd_valid_q      <= 1'b0;
      timeout_err_q   <= 1'b0;
    end else begin
      words_q         <= words_d;
      out_q           <= out_d;
      fresh_q         <= fresh_d;
      pst_q           <= pst_d;
      rst_st_q        <= rst_st_d;
      out_valid_q     <= out_valid_d;
      in_ready_q      <= in_ready_d;
      wr_resp_q       <= wr_resp_d;
      wr_resp_valid_q <= wr_resp_valid_d;
      rd_data_q       <= rd_data_d;
      rd_valid_q      <= rd_valid_d;
      timeout_err_q   <= timeout_err_d;
    end
  end

  assign ps_wr_resp_o       = wr_resp_q;
  assign ps_wr_resp_valid_o = wr_resp_valid_q;
  assign ps_rd_data_o       = rd_data_q;
  assign ps_rd_valid_o      = rd_valid_q;
  assign rtl_out_data_o     = out_q;
  assign rtl_out_valid_o    = out_valid_q;
  assign rtl_in_ready_o     = in_ready_q;
  assign timeout_err_o      = timeout_err_q;

endmodule

// File: tb/tb_mmio_bigreg_bridge.sv
// tb/tb_mmio_bigreg_bridge.sv - scoreboard bench for a DIR=0 and a DIR=1 bridge instance (NUM_WORDS=2)
module tb_mmio_bigreg_bridge;

  localparam logic [1:0] OK = 2'b00;
  localparam logic [1:0] SE = 2'b10;
  localparam logic [1:0] DE = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [1:0]  exp_resp_q[$];
  logic [15:0] exp_rd_q[$];
  logic [1:0]  er;
  logic [15:0] ed;

  logic        a_we = 0, a_re = 0, a_ordy = 0;
  logic [2:0]  a_wi = 0, a_ri = 0;
  logic [15:0] a_wd = 0;
  logic [1:0]  a_resp;
  logic        a_resp_v, a_rd_v, a_ov, a_ir, a_to;
  logic [15:0] a_rd;
  logic [31:0] a_od;

  logic        b_we = 0, b_re = 0, b_iv = 0;
  logic [2:0]  b_wi = 0, b_ri = 0;
  logic [15:0] b_wd = 0;
  logic [31:0] b_id = 0;
  logic [1:0]  b_resp;
  logic        b_resp_v, b_rd_v, b_ov, b_ir, b_to;
  logic [15:0] b_rd;
  logic [31:0] b_od;

  mmio_bigreg_bridge #(.NUM_WORDS(2), .WORD_WIDTH(16), .DIR(0), .TIMEOUT_CYCLES(8)) u_a (
    .clk_i(clk), .rst_i(rst),
    .ps_wr_en_i(a_we), .ps_wr_idx_i(a_wi), .ps_wr_data_i(a_wd),
    .ps_wr_resp_o(a_resp), .ps_wr_resp_valid_o(a_resp_v),
    .ps_rd_en_i(a_re), .ps_rd_idx_i(a_ri), .ps_rd_data_o(a_rd), .ps_rd_valid_o(a_rd_v),
    .rtl_out_data_o(a_od), .rtl_out_valid_o(a_ov), .rtl_out_ready_i(a_ordy),
    .rtl_in_data_i(32'h0), .rtl_in_valid_i(1'b0), .rtl_in_ready_o(a_ir),
    .timeout_err_o(a_to)
  );

  mmio_bigreg_bridge #(.NUM_WORDS(2), .WORD_WIDTH(16), .DIR(1), .TIMEOUT_CYCLES(8)) u_b (
    .clk_i(clk), .rst_i(rst),
    .ps_wr_en_i(b_we), .ps_wr_idx_i(b_wi), .ps_wr_data_i(b_wd),
    .ps_wr_resp_o(b_resp), .ps_wr_resp_valid_o(b_resp_v),
    .ps_rd_en_i(b_re), .ps_rd_idx_i(b_ri), .ps_rd_data_o(b_rd), .ps_rd_valid_o(b_rd_v),
    .rtl_out_data_o(b_od), .rtl_out_valid_o(b_ov), .rtl_out_ready_i(1'b0),
    .rtl_in_data_i(b_id), .rtl_in_valid_i(b_iv), .rtl_in_ready_o(b_ir),
    .timeout_err_o(b_to)
  );

  task automatic step();
    @(posedge clk);
    #1;
    a_we = 0; a_re = 0; a_ordy = 0;
    b_we = 0; b_re = 0; b_iv = 0;
  endtask

  task automatic a_wr_seq(input logic [2:0] idx[], input logic [15:0] dat[], input logic [1:0] exp[]);
    for (int i = 0; i < idx.size(); i++) begin
      exp_resp_q.push_back(exp[i]);
      a_we = 1; a_wi = idx[i]; a_wd = dat[i];
      step();
      er = exp_resp_q.pop_front();
      checks++; if (a_resp_v !== 1'b1 || a_resp !== er) begin failures++; $display("FAIL a_wr_resp idx=%0d: got v=%b resp=%b expected resp=%b", idx[i], a_resp_v, a_resp, er); end
    end
  endtask

  task automatic rd_seq(input logic sel_b, input logic [2:0] idx[], input logic [15:0] exp[]);
    for (int i = 0; i < idx.size(); i++) begin
      exp_rd_q.push_back(exp[i]);
      if (sel_b) begin b_re = 1; b_ri = idx[i]; end else begin a_re = 1; a_ri = idx[i]; end
      step();
      ed = exp_rd_q.pop_front();
      checks++; if ((sel_b ? b_rd_v : a_rd_v) !== 1'b1 || (sel_b ? b_rd : a_rd) !== ed) begin failures++; $display("FAIL rd dut=%0d idx=%0d: got %h expected %h", sel_b, idx[i], sel_b ? b_rd : a_rd, ed); end
    end
  endtask

  task automatic test_reset();
    rst = 1;
    step(); step();
    checks++; if ({a_resp_v, a_rd_v, a_ov, a_to, a_ir, b_resp_v, b_rd_v, b_ov, b_ir, b_to} !== 10'b0) begin failures++; $display("FAIL reset_flags: got %b expected 0", {a_resp_v, a_rd_v, a_ov, a_to, a_ir, b_resp_v, b_rd_v, b_ov, b_ir, b_to}); end
    checks++; if (a_od !== 32'h0 || a_rd !== 16'h0 || b_rd !== 16'h0) begin failures++; $display("FAIL reset_data: got od=%h rd=%h/%h expected 0", a_od, a_rd, b_rd); end
    rst = 0;
    step();
    checks++; if (b_ir !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", b_ir); end
  endtask

  task automatic test_commit();
    a_wr_seq('{3'd0, 3'd1, 3'd2}, '{16'h1234, 16'hABCD, 16'h0}, '{OK, OK, OK});
    checks++; if (a_od !== 32'hABCD1234 || a_ov !== 1'b1) begin failures++; $display("FAIL commit_out: got %h v=%b expected abcd1234 v=1", a_od, a_ov); end
    step();
    checks++; if (a_ov !== 1'b1) begin failures++; $display("FAIL commit_hold: got %b expected 1", a_ov); end
    a_ordy = 1;
    step();
    checks++; if (a_ov !== 1'b0 || a_od !== 32'hABCD1234) begin failures++; $display("FAIL commit_handshake: got v=%b od=%h expected v=0 od=abcd1234", a_ov, a_od); end
  endtask

  task automatic test_partial();
    a_wr_seq('{3'd0, 3'd2}, '{16'h1234, 16'h0}, '{OK, SE});
    checks++; if (a_ov !== 1'b0) begin failures++; $display("FAIL partial_valid: got %b expected 0", a_ov); end
    rd_seq(1'b0, '{3'd2, 3'd0}, '{16'h0000, 16'h1234});
  endtask

  task automatic test_busy();
    a_wr_seq('{3'd1, 3'd2, 3'd0, 3'd1, 3'd2}, '{16'h5555, 16'h0, 16'h1111, 16'h2222, 16'h0}, '{OK, OK, OK, OK, SE});
    checks++; if (a_od !== 32'h55551234 || a_ov !== 1'b1) begin failures++; $display("FAIL busy_hold: got %h v=%b expected 55551234 v=1", a_od, a_ov); end
    rd_seq(1'b0, '{3'd2}, '{16'h0003});
    exp_resp_q.push_back(OK);
    exp_rd_q.push_back(16'h1111);
    a_we = 1; a_wi = 3'd2; a_ordy = 1; a_re = 1; a_ri = 3'd0;
    step();
    er = exp_resp_q.pop_front();
    ed = exp_rd_q.pop_front();
    checks++; if (a_resp_v !== 1'b1 || a_resp !== er) begin failures++; $display("FAIL commit_wins_resp: got %b expected %b", a_resp, er); end
    checks++; if (a_rd_v !== 1'b1 || a_rd !== ed) begin failures++; $display("FAIL same_cycle_read: got %h expected %h", a_rd, ed); end
    checks++; if (a_ov !== 1'b1 || a_od !== 32'h22221111) begin failures++; $display("FAIL commit_wins_out: got v=%b od=%h expected v=1 od=22221111", a_ov, a_od); end
  endtask

  task automatic test_dir1();
    b_iv = 1; b_id = 32'hDEADBEEF;
    step();
    checks++; if (b_ir !== 1'b0) begin failures++; $display("FAIL snap_ready: got %b expected 0", b_ir); end
    b_iv = 1; b_id = 32'h0;
    step();
    rd_seq(1'b1, '{3'd0, 3'd1, 3'd2}, '{16'hBEEF, 16'hDEAD, 16'h0001});
    for (int i = 0; i < 4; i++) begin
      exp_resp_q.push_back(i == 0 ? OK : (i == 1 ? SE : (i == 2 ? OK : DE)));
      b_we = 1; b_wi = (i == 0 || i == 2) ? 3'd2 : (i == 1 ? 3'd0 : 3'd5);
      step();
      er = exp_resp_q.pop_front();
      checks++; if (b_resp_v !== 1'b1 || b_resp !== er) begin failures++; $display("FAIL b_wr_resp step=%0d: got v=%b resp=%b expected %b", i, b_resp_v, b_resp, er); end
      if (i == 0) begin
        checks++; if (b_ir !== 1'b1) begin failures++; $display("FAIL ack_ready: got %b expected 1", b_ir); end
      end
    end
    rd_seq(1'b1, '{3'd5, 3'd2}, '{16'h0000, 16'h0000});
    checks++; if (b_ov !== 1'b0 || b_od !== 32'h0 || a_ir !== 1'b0) begin failures++; $display("FAIL dir_tieoffs: got b_ov=%b b_od=%h a_ir=%b expected 0", b_ov, b_od, a_ir); end
    b_iv = 1; b_id = 32'h12345678;
    step();
    rd_seq(1'b1, '{3'd2, 3'd1}, '{16'h0001, 16'h1234});
  endtask

  task automatic test_reset_mid();
    rst = 1;
    step();
    checks++; if ({a_ov, a_resp_v, a_rd_v, b_ir, b_rd_v, a_to} !== 6'b0 || a_od !== 32'h0) begin failures++; $display("FAIL mid_reset: got flags=%b od=%h expected 0", {a_ov, a_resp_v, a_rd_v, b_ir, b_rd_v, a_to}, a_od); end
    rst = 0;
    step();
    a_wr_seq('{3'd2, 3'd0, 3'd2, 3'd1, 3'd2}, '{16'h0, 16'hAAAA, 16'h0, 16'hBBBB, 16'h0}, '{SE, OK, SE, OK, OK});
    checks++; if (a_od !== 32'hBBBBAAAA || a_ov !== 1'b1) begin failures++; $display("FAIL post_reset_commit: got %h v=%b expected bbbbaaaa v=1", a_od, a_ov); end
    rd_seq(1'b1, '{3'd2, 3'd0}, '{16'h0000, 16'h0000});
  endtask

  task automatic test_timeout();
    int seen;
    a_ordy = 1;
    step();
    a_wr_seq('{3'd0}, '{16'h0F0F}, '{OK});
`ifdef BIGREG_TIMEOUT_EN
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++; if (a_to !== logic'(k == 8)) begin failures++; $display("FAIL timeout_pulse cycle=%0d: got %b expected %b", k, a_to, k == 8); end
    end
    a_wr_seq('{3'd2}, '{16'h0}, '{SE});
    rd_seq(1'b0, '{3'd0}, '{16'h0F0F});
`else
    seen = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (a_to !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL timeout_tied: got %0d pulses expected 0", seen); end
    a_wr_seq('{3'd1, 3'd2}, '{16'hF0F0, 16'h0}, '{OK, OK});
    checks++; if (a_od !== 32'hF0F00F0F) begin failures++; $display("FAIL fresh_persist: got %h expected f0f00f0f", a_od); end
`endif
  endtask

  initial begin
    test_reset();
    test_commit();
    test_partial();
    test_busy();
    test_dir1();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
